// File: rtl/fp_mult_arb_pkg.sv
// Shared defaults and FSM encoding for the multiplier-sharing arbiter.
package fp_mult_arb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REQ    = 4;
  localparam int MULT_DELAY = 7;
  localparam int TIMEOUT    = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_req
);

  logic             found;
  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      pos = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one external FP multiplier among NUM_REQ requesters, one operation at a time,
// with a WAIT-state timeout that returns error=1 and a zero product.
module fp_mult_arbiter #(
  parameter int DATA_WIDTH = fp_mult_arb_pkg::DATA_WIDTH,
  parameter int NUM_REQ    = fp_mult_arb_pkg::NUM_REQ,
  parameter int MULT_DELAY = fp_mult_arb_pkg::MULT_DELAY,
  parameter int TIMEOUT    = fp_mult_arb_pkg::TIMEOUT
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_product,
  output logic                          resp_error,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         mult_a,
  output logic [DATA_WIDTH-1:0]         mult_b,
  output logic                          mult_start,
  input  logic [DATA_WIDTH-1:0]         mult_product,
  input  logic                          mult_product_ready
);
  import fp_mult_arb_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  if (TIMEOUT < MULT_DELAY) begin : g_bad_timeout
    $error("fp_mult_arbiter: TIMEOUT must be >= MULT_DELAY");
  end

  state_t               state, state_n;
  logic [CNT_W-1:0]     count, count_n, count_inc;
  logic [NUM_REQ-1:0]   owner, owner_n;
  logic [IDX_W-1:0]     owner_idx, owner_idx_n;
  logic [IDX_W-1:0]     last_grant, last_grant_n;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 any_req;

  logic [NUM_REQ-1:0]   grant_n, resp_valid_n;
  logic [DATA_WIDTH-1:0] resp_product_n, mult_a_n, mult_b_n;
  logic                 resp_error_n, busy_n, start_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  assign count_inc = count + CNT_W'(1);

  // Every output is the registered image of its *_n value, so each output
  // reflects the state being entered on this edge.
  always_comb begin
    state_n        = state;
    count_n        = count;
    owner_n        = owner;
    owner_idx_n    = owner_idx;
    last_grant_n   = last_grant;
    mult_a_n       = mult_a;
    mult_b_n       = mult_b;
    grant_n        = '0;
    start_n        = 1'b0;
    resp_valid_n   = '0;
    resp_product_n = '0;
    resp_error_n   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_n = arb_grant;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
              owner_idx_n = IDX_W'(i);
              mult_a_n    = req_a[i*DATA_WIDTH +: DATA_WIDTH];
              mult_b_n    = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          grant_n = arb_grant;
          start_n = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        count_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        count_n = count_inc;
        // A ready arriving on the timeout cycle still delivers the product.
        if (mult_product_ready) begin
          resp_valid_n   = owner;
          resp_product_n = mult_product;
          state_n        = RESP;
        end else if (count_inc == CNT_W'(TIMEOUT)) begin
          resp_valid_n = owner;
          resp_error_n = 1'b1;
          state_n      = RESP;
        end
      end
      RESP: begin
        last_grant_n = owner_idx;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      owner        <= '0;
      owner_idx    <= '0;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      req_grant    <= '0;
      resp_valid   <= '0;
      resp_product <= '0;
      resp_error   <= 1'b0;
      busy         <= 1'b0;
      mult_a       <= '0;
      mult_b       <= '0;
      mult_start   <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      owner        <= owner_n;
      owner_idx    <= owner_idx_n;
      last_grant   <= last_grant_n;
      req_grant    <= grant_n;
      resp_valid   <= resp_valid_n;
      resp_product <= resp_product_n;
      resp_error   <= resp_error_n;
      busy         <= busy_n;
      mult_a       <= mult_a_n;
      mult_b       <= mult_b_n;
      mult_start   <= start_n;
    end
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter; the bench itself plays the external multiplier.
module tb_fp_mult_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 15;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [NR-1:0]     req_grant, resp_valid;
  logic [DW-1:0]     resp_product, mult_a, mult_b, mult_product;
  logic              resp_error, busy, mult_start, mult_product_ready;

  int errors = 0;
  int checks = 0;
  logic [NR-1:0] exp_q[$];

  always #5 clock = ~clock;

  fp_mult_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MULT_DELAY(7), .TIMEOUT(TO)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_a              (req_a),
    .req_b              (req_b),
    .req_grant          (req_grant),
    .resp_valid         (resp_valid),
    .resp_product       (resp_product),
    .resp_error         (resp_error),
    .busy               (busy),
    .mult_a             (mult_a),
    .mult_b             (mult_b),
    .mult_start         (mult_start),
    .mult_product       (mult_product),
    .mult_product_ready (mult_product_ready)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0;
    mult_product_ready = 1'b0;
    mult_product = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req_a = '1;
    req_b = '1;
    req_valid = '1;
    mult_product_ready = 1'b1;
    mult_product = '1;
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({req_grant, resp_valid, resp_product, resp_error, busy, mult_a, mult_b, mult_start} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b resp_valid=%b prod=%h err=%b busy=%b a=%h b=%h start=%b, want all 0",
               req_grant, resp_valid, resp_product, resp_error, busy, mult_a, mult_b, mult_start);
    end
    req_valid = '0;
    mult_product_ready = 1'b0;
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || req_grant !== '0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b grant=%b resp_valid=%b, want 0/0000/0000", busy, req_grant, resp_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_a = '0;
    req_b = '0;
    req_a[31:0] = 32'h4000_0000;
    req_b[31:0] = 32'h4040_0000;
    req_valid = 4'b0001;
    tick();  // cycle 1
    checks++;
    if (req_grant !== 4'b0001 || mult_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got grant=%b start=%b busy=%b, want 0001/1/1", req_grant, mult_start, busy);
    end
    checks++;
    if (mult_a !== 32'h4000_0000 || mult_b !== 32'h4040_0000) begin
      errors++;
      $display("FAIL single_operands: got a=%h b=%h, want 40000000/40400000", mult_a, mult_b);
    end
    req_valid = '0;
    tick();  // cycle 2
    for (int c = 2; c < 8; c++) begin
      checks++;
      if (req_grant !== '0 || mult_start !== 1'b0 || resp_valid !== '0 || mult_a !== 32'h4000_0000) begin
        errors++;
        $display("FAIL single_wait_c%0d: got grant=%b start=%b resp_valid=%b a=%h, want 0000/0/0000/40000000",
                 c, req_grant, mult_start, resp_valid, mult_a);
      end
      if (c == 3) req_valid = 4'b0010;
      if (c == 5) req_valid = '0;
      tick();
    end
    mult_product_ready = 1'b1;  // cycle 8
    mult_product = 32'h40C0_0000;
    tick();  // cycle 9
    mult_product_ready = 1'b0;
    mult_product = 32'hDEAD_BEEF;
    checks++;
    if (resp_valid !== 4'b0001 || resp_product !== 32'h40C0_0000 || resp_error !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: got valid=%b prod=%h err=%b, want 0001/40c00000/0", resp_valid, resp_product, resp_error);
    end
    tick();  // cycle 10
    checks++;
    if (resp_valid !== '0 || resp_product !== '0 || busy !== 1'b0 || req_grant !== '0) begin
      errors++;
      $display("FAIL single_after: got valid=%b prod=%h busy=%b grant=%b, want 0000/0/0/0000",
               resp_valid, resp_product, busy, req_grant);
    end
  endtask

  task automatic test_fairness();
    logic [NR-1:0] g;
    int w;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = 32'h4000_0000 + i;
      req_b[i*DW +: DW] = 32'h4100_0000 + i;
    end
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
    end
    req_valid = 4'b1111;
    for (int op = 0; op < 8; op++) begin
      g = exp_q.pop_front();
      w = 0;
      while (req_grant === '0 && w < 10) begin
        tick();
        w++;
      end
      checks++;
      if (req_grant !== g) begin
        errors++;
        $display("FAIL fair_grant_op%0d: got grant=%b after %0d cycles, want %b", op, req_grant, w, g);
      end
      checks++;
      if (mult_a !== 32'h4000_0000 + (op % NR) || mult_b !== 32'h4100_0000 + (op % NR)) begin
        errors++;
        $display("FAIL fair_operands_op%0d: got a=%h b=%h, want requester %0d operands", op, mult_a, mult_b, op % NR);
      end
      tick();  // WAIT
      mult_product_ready = 1'b1;
      mult_product = 32'h3F80_0000 + op;
      tick();  // RESP
      mult_product_ready = 1'b0;
      checks++;
      if (resp_valid !== g || resp_product !== 32'h3F80_0000 + op) begin
        errors++;
        $display("FAIL fair_resp_op%0d: got valid=%b prod=%h, want %b/%h", op, resp_valid, resp_product, g, 32'h3F80_0000 + op);
      end
      tick();  // IDLE
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic run_to_wait_end(input logic ready_on_timeout, input string tag);
    do_reset();
    req_a = '0;
    req_b = '0;
    req_a[31:0] = 32'h4040_0000;
    req_b[31:0] = 32'h4040_0000;
    req_valid = 4'b0001;
    tick();  // cycle 1
    checks++;
    if (req_grant !== 4'b0001) begin
      errors++;
      $display("FAIL %s_grant: got %b, want 0001", tag, req_grant);
    end
    req_valid = '0;
    for (int c = 2; c <= 16; c++) begin
      tick();
      checks++;
      if (resp_valid !== '0) begin
        errors++;
        $display("FAIL %s_early_c%0d: got resp_valid=%b, want 0000", tag, c, resp_valid);
      end
    end
    if (ready_on_timeout) begin  // cycle 16 is the timeout cycle
      mult_product_ready = 1'b1;
      mult_product = 32'h4110_0000;
    end
    tick();  // cycle 17
    mult_product_ready = 1'b0;
  endtask

  task automatic test_timeout();
    run_to_wait_end(1'b0, "timeout");
    checks++;
    if (resp_valid !== 4'b0001 || resp_error !== 1'b1 || resp_product !== '0) begin
      errors++;
      $display("FAIL timeout_resp: got valid=%b err=%b prod=%h, want 0001/1/0", resp_valid, resp_error, resp_product);
    end
    tick();  // 18
    tick();  // 19
    tick();  // 20: late ready
    mult_product_ready = 1'b1;
    mult_product = 32'h4110_0000;
    tick();
    mult_product_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (resp_valid !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL timeout_late_ready_%0d: got valid=%b busy=%b, want 0000/0", c, resp_valid, busy);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    run_to_wait_end(1'b1, "simul");
    checks++;
    if (resp_valid !== 4'b0001 || resp_error !== 1'b0 || resp_product !== 32'h4110_0000) begin
      errors++;
      $display("FAIL simul_resp: got valid=%b err=%b prod=%h, want 0001/0/41100000", resp_valid, resp_error, resp_product);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req_a[31:0] = 32'h4000_0000;
    req_b[31:0] = 32'h4000_0000;
    req_a[95:64] = 32'h4080_0000;
    req_b[95:64] = 32'h3F80_0000;
    req_valid = 4'b0001;
    tick();  // 1
    req_valid = '0;
    tick();  // 2
    tick();  // 3
    tick();  // 4
    reset_n = 1'b0;
    tick();  // 5
    reset_n = 1'b1;
    checks++;
    if ({req_grant, resp_valid, resp_product, resp_error, busy, mult_a, mult_b, mult_start} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got grant=%b valid=%b prod=%h err=%b busy=%b a=%h b=%h start=%b, want all 0",
               req_grant, resp_valid, resp_product, resp_error, busy, mult_a, mult_b, mult_start);
    end
    tick();  // 6: stale product arrives
    mult_product_ready = 1'b1;
    mult_product = 32'h4080_0000;
    tick();  // 7
    mult_product_ready = 1'b0;
    checks++;
    if (resp_valid !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale: got valid=%b busy=%b, want 0000/0", resp_valid, busy);
    end
    req_valid = 4'b0100;
    tick();  // 8
    checks++;
    if (req_grant !== 4'b0100 || mult_a !== 32'h4080_0000) begin
      errors++;
      $display("FAIL midreset_regrant: got grant=%b a=%h, want 0100/40800000", req_grant, mult_a);
    end
    req_valid = '0;
    tick();
    mult_product_ready = 1'b1;
    mult_product = 32'h4080_0000;
    tick();
    mult_product_ready = 1'b0;
    checks++;
    if (resp_valid !== 4'b0100 || resp_product !== 32'h4080_0000) begin
      errors++;
      $display("FAIL midreset_resp: got valid=%b prod=%h, want 0100/40800000", resp_valid, resp_product);
    end
    tick();
  endtask

  task automatic test_withdrawal();
    int w;
    logic saw_one;
    do_reset();
    saw_one = 1'b0;
    req_valid = 4'b1011;
    tick();  // 1
    checks++;
    if (req_grant !== 4'b0001) begin
      errors++;
      $display("FAIL withdraw_first: got grant=%b, want 0001", req_grant);
    end
    req_valid = 4'b1010;
    tick();  // 2: requester 1 withdraws during WAIT
    req_valid = 4'b1000;
    tick();
    tick();
    mult_product_ready = 1'b1;
    mult_product = 32'h4000_0000;
    tick();
    mult_product_ready = 1'b0;
    checks++;
    if (resp_valid !== 4'b0001) begin
      errors++;
      $display("FAIL withdraw_resp0: got valid=%b, want 0001", resp_valid);
    end
    w = 0;
    while (req_grant === '0 && w < 10) begin
      tick();
      w++;
    end
    checks++;
    if (req_grant !== 4'b1000) begin
      errors++;
      $display("FAIL withdraw_next: got grant=%b after %0d cycles, want 1000", req_grant, w);
    end
    req_valid = '0;
    tick();
    mult_product_ready = 1'b1;
    tick();
    mult_product_ready = 1'b0;
    checks++;
    if (resp_valid !== 4'b1000) begin
      errors++;
      $display("FAIL withdraw_resp3: got valid=%b, want 1000", resp_valid);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (req_grant[1]) saw_one = 1'b1;
    end
    checks++;
    if (saw_one !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_never1: got saw_grant1=%b busy=%b, want 0/0", saw_one, busy);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    mult_product = '0;
    mult_product_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    test_withdrawal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_mult_arbiter.md
FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

Interface
REQ-001 The parameters SHALL be as follows, one per line: name, default, meaning.
  DATA_WIDTH, 32, IEEE-754 single operand/product width.
  NUM_REQ, 4, number of requesters sharing one float_point_multiplier_wrapper.
  MULT_DELAY, 7, nominal multiplier latency in cycles (start to product_ready).
  TIMEOUT, 15, maximum WAIT cycles before error; SHALL satisfy TIMEOUT >= MULT_DELAY (elaboration-time check).
REQ-002 The ports SHALL be as follows, one per line: name, direction, width, meaning.
  clock  in  1  single clock, rising edge.
  reset_n  in  1  synchronous active-low reset.
  req_valid  in  NUM_REQ  per-requester request.
  req_a  in  NUM_REQ*DATA_WIDTH  operand A; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
  req_b  in  NUM_REQ*DATA_WIDTH  operand B; same packing.
  req_grant  out  NUM_REQ  one-hot, one-cycle pulse: operands captured.
  resp_valid  out  NUM_REQ  one-hot, one-cycle pulse: result for requester i.
  resp_product  out  DATA_WIDTH  product; valid only while resp_valid is nonzero.
  resp_error  out  1  timeout flag; valid only while resp_valid is nonzero.
  busy  out  1  high in every state except IDLE.
  mult_a  out  DATA_WIDTH  to multiplier inp_a.
  mult_b  out  DATA_WIDTH  to multiplier inp_b.
  mult_start  out  1  to multiplier inp_data_ready.
  mult_product  in  DATA_WIDTH  from multiplier out_product.
  mult_product_ready  in  1  from multiplier out_product_ready.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-004 In IDLE with req_valid nonzero, the block SHALL select an owner by round-robin, searching from last_grant+1 (modulo NUM_REQ), latch the owner's operands into mult_a/mult_b, and go to ISSUE.
REQ-005 In IDLE with req_valid zero, the block SHALL remain in IDLE.
REQ-006 In ISSUE (exactly one cycle), mult_start SHALL be 1 and req_grant[owner] SHALL be 1; the next state SHALL be WAIT with the timeout counter cleared.
REQ-007 mult_start and req_grant SHALL be 0 in every state other than ISSUE.
REQ-008 mult_a/mult_b SHALL hold their values from ISSUE until the next capture.
REQ-009 In WAIT, the counter SHALL increment each cycle; its width SHALL be $clog2(TIMEOUT+1).
REQ-010 In WAIT, when mult_product_ready is 1, the block SHALL capture mult_product, set error=0, and go to RESP.
REQ-011 In WAIT, when the counter equals TIMEOUT and mult_product_ready is 0, the block SHALL set product=0, set error=1, and go to RESP.
REQ-012 If mult_product_ready and the timeout occur in the same cycle, the ready SHALL win (error=0).
REQ-013 In RESP (one cycle), resp_valid[owner]=1 and resp_product/resp_error SHALL be driven; last_grant SHALL be set to owner; the next state SHALL be IDLE.
REQ-014 resp_valid SHALL be 0 outside RESP, and resp_product/resp_error SHALL be 0 outside RESP.
REQ-015 Latency: req_valid sampled in IDLE at cycle 0 -> grant/start at cycle 1 -> resp_valid one cycle after mult_product_ready (nominal: cycle 1+MULT_DELAY+1).
REQ-016 mult_product_ready outside WAIT SHALL be ignored (stale/late result discarded).
REQ-017 A requester SHALL hold req_valid and operands until req_grant; deassertion before grant withdraws the request without service.
REQ-018 req_valid during ISSUE/WAIT/RESP SHALL be ignored until the next IDLE; only one operation SHALL be outstanding.
REQ-019 With all requesters continuously valid, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0; no requester SHALL wait more than NUM_REQ-1 operations.

Reset
REQ-020 While reset_n=0 at a clock edge, state SHALL become IDLE, the counter 0, and last_grant NUM_REQ-1 (requester 0 first after reset).
REQ-021 While reset_n=0 at a clock edge, every output SHALL become 0.
REQ-022 Reset mid-operation SHALL drop the in-flight result: no resp_valid for it, and a subsequent mult_product_ready SHALL be ignored per REQ-016.

Structure
REQ-023 Package fp_mult_arb_pkg SHALL hold the default constants (DATA_WIDTH, NUM_REQ, MULT_DELAY, TIMEOUT) and the FSM state enum.
REQ-024 Round-robin selection SHALL be one sub-module, rr_arbiter (combinational: req vector plus last_grant in, one-hot grant out, any_req out).
REQ-025 The multiplier SHALL be instantiated outside this block, connected through the mult_* ports.

Verification
REQ-026 Single request: req_valid=0001, a=0x40000000 (2.0), b=0x40400000 (3.0), multiplier model ready after 7 cycles -> grant=0001 at cycle 1, resp_valid=0001 at cycle 9, resp_product=0x40C00000, resp_error=0.
REQ-027 Fairness: req_valid=1111 held for 8 operations -> grant order 0,1,2,3,0,1,2,3; each resp_valid goes to the matching owner.
REQ-028 Timeout: multiplier model never asserts ready -> resp_error=1, resp_product=0, resp_valid at cycle 1+TIMEOUT+1; a late ready 3 cycles afterwards produces no response.
REQ-029 Simultaneous events: ready asserted exactly on the TIMEOUT cycle -> resp_error=0 and the product is returned.
REQ-030 Reset mid-WAIT: reset_n=0 for 1 cycle at cycle 4 -> all outputs 0 and no resp_valid; a new request from requester 2 afterwards is granted with grant=0100.
REQ-031 Withdrawal: requester 1 drops req_valid while requester 0 is in WAIT -> requester 1 is never granted; requester 3 is granted next.
